// File: rtl/vx_mem_pkg.sv
// Shared sizing helpers for the memory request arbiter and its response demux.
// Both sides derive source-index and widened tag widths from the same functions.
package vx_mem_pkg;

  localparam int DEF_NUM_REQS     = 4;
  localparam int DEF_DATA_WIDTH   = 512;
  localparam int DEF_ADDR_WIDTH   = 26;
  localparam int DEF_TAG_IN_WIDTH = 8;

  // A single source still needs one index bit so the tag field never collapses to zero width.
  function automatic int log2_reqs(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  function automatic int data_size(input int data_width);
    return data_width / 8;
  endfunction

  // Outgoing tag carries the source index in its LSBs so responses can be routed back.
  function automatic int tag_out_width(input int tag_in_width, input int num_reqs);
    return tag_in_width + log2_reqs(num_reqs);
  endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin grant: combinational search from rr_ptr, zero latency; pointer advances
// only when enable accepts the grant, so stalls and idle cycles leave it untouched.
module vx_rr_arbiter
  import vx_mem_pkg::*;
#(
  parameter int NUM_REQS = DEF_NUM_REQS,
  localparam int LOG_NUM_REQS = log2_reqs(NUM_REQS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQS-1:0]     requests,
  input  logic                    enable,
  output logic [NUM_REQS-1:0]     grant,
  output logic [LOG_NUM_REQS-1:0] grant_index,
  output logic                    grant_valid
);

  localparam int IW = LOG_NUM_REQS + 1;
  typedef logic [IW-1:0] idx_t;

  logic [LOG_NUM_REQS-1:0] rr_ptr;
  logic [LOG_NUM_REQS-1:0] rr_ptr_nxt;

  always_comb begin
    idx_t idx;
    idx         = '0;
    grant       = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      // Extra index bit absorbs rr_ptr+i before folding back into range.
      idx = idx_t'(rr_ptr) + idx_t'(i);
      if (idx >= idx_t'(NUM_REQS)) begin
        idx = idx - idx_t'(NUM_REQS);
      end
      if (!grant_valid && requests[idx[LOG_NUM_REQS-1:0]]) begin
        grant_valid = 1'b1;
        grant_index = idx[LOG_NUM_REQS-1:0];
      end
    end
    grant[grant_index] = grant_valid;
  end

  always_comb begin
    rr_ptr_nxt = grant_index + 1'b1;
    if (int'(grant_index) == NUM_REQS - 1) begin
      rr_ptr_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (enable && grant_valid) begin
      rr_ptr <= rr_ptr_nxt;
    end
  end

endmodule

// File: rtl/vx_mem_req_arb.sv
// Merges NUM_REQS request streams into one round-robin arbitrated stream, 1-cycle latency;
// single output register, refilled in the same cycle it drains, holds stable under backpressure.
module vx_mem_req_arb
  import vx_mem_pkg::*;
#(
  parameter int NUM_REQS     = DEF_NUM_REQS,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int TAG_IN_WIDTH = DEF_TAG_IN_WIDTH,
  localparam int DATA_SIZE     = data_size(DATA_WIDTH),
  localparam int LOG_NUM_REQS  = log2_reqs(NUM_REQS),
  localparam int TAG_OUT_WIDTH = tag_out_width(TAG_IN_WIDTH, NUM_REQS)
) (
  input  logic                             clk,
  input  logic                             reset_n,

  input  logic [NUM_REQS-1:0]              in_valid,
  input  logic [NUM_REQS-1:0]              in_rw,
  input  logic [NUM_REQS*DATA_SIZE-1:0]    in_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   in_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] in_tag,
  output logic [NUM_REQS-1:0]              in_ready,

  output logic                             out_valid,
  output logic                             out_rw,
  output logic [DATA_SIZE-1:0]             out_byteen,
  output logic [ADDR_WIDTH-1:0]            out_addr,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [TAG_OUT_WIDTH-1:0]         out_tag,
  input  logic                             out_ready
);

  logic [NUM_REQS-1:0]     grant;
  logic [LOG_NUM_REQS-1:0] grant_index;
  logic                    grant_valid;
  logic                    load_en;
  logic                    fire_in;

  logic                    sel_rw;
  logic [DATA_SIZE-1:0]    sel_byteen;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [TAG_IN_WIDTH-1:0] sel_tag;

  // The register can take a new request when it is empty or draining this cycle.
  assign load_en = !out_valid || out_ready;
  assign fire_in = grant_valid && load_en;

  vx_rr_arbiter #(
    .NUM_REQS (NUM_REQS)
  ) u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .requests    (in_valid),
    .enable      (load_en),
    .grant       (grant),
    .grant_index (grant_index),
    .grant_valid (grant_valid)
  );

  // Gated by reset_n so no source sees an accept while the arbiter is held in reset.
  assign in_ready = grant & {NUM_REQS{load_en && reset_n}};

  always_comb begin
    sel_rw     = in_rw[grant_index];
    sel_byteen = in_byteen[grant_index * DATA_SIZE    +: DATA_SIZE];
    sel_addr   = in_addr  [grant_index * ADDR_WIDTH   +: ADDR_WIDTH];
    sel_data   = in_data  [grant_index * DATA_WIDTH   +: DATA_WIDTH];
    sel_tag    = in_tag   [grant_index * TAG_IN_WIDTH +: TAG_IN_WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_rw     <= 1'b0;
      out_byteen <= '0;
      out_addr   <= '0;
      out_data   <= '0;
      out_tag    <= '0;
    end else if (fire_in) begin
      out_valid  <= 1'b1;
      out_rw     <= sel_rw;
      out_byteen <= sel_byteen;
      out_addr   <= sel_addr;
      out_data   <= sel_data;
      out_tag    <= {sel_tag, grant_index};
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vx_mem_req_arb.sv
// Directed scenarios plus a randomized scoreboard run for the round-robin request arbiter.
module tb_vx_mem_req_arb;

  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int AW  = 26;
  localparam int TW  = 8;
  localparam int DS  = DW / 8;
  localparam int TOW = TW + 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_rw;
  logic [N*DS-1:0]   in_byteen;
  logic [N*AW-1:0]   in_addr;
  logic [N*DW-1:0]   in_data;
  logic [N*TW-1:0]   in_tag;
  logic [N-1:0]      in_ready;
  logic              out_valid;
  logic              out_rw;
  logic [DS-1:0]     out_byteen;
  logic [AW-1:0]     out_addr;
  logic [DW-1:0]     out_data;
  logic [TOW-1:0]    out_tag;
  logic              out_ready;

  typedef struct packed {
    logic           rw;
    logic [DS-1:0]  be;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic [TOW-1:0] tag;
  } rec_t;

  rec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vx_mem_req_arb #(
    .NUM_REQS     (N),
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .TAG_IN_WIDTH (TW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_rw      (in_rw),
    .in_byteen  (in_byteen),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_tag     (in_tag),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_rw     (out_rw),
    .out_byteen (out_byteen),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_ready  (out_ready)
  );

  // Expected output record for a fixed per-source request used by the directed tests.
  function automatic rec_t mk_req(input int s);
    rec_t r;
    r.rw   = s[0];
    r.be   = DS'(8'h01 << s);
    r.addr = AW'(26'h100 + s);
    r.data = {32'hDA7A_0000 + 32'(s), 32'hC0DE_0000 + 32'(s)};
    r.tag  = {TW'(8'hA0 + s), 2'(s)};
    return r;
  endfunction

  function automatic rec_t out_rec();
    return {out_rw, out_byteen, out_addr, out_data, out_tag};
  endfunction

  task automatic drive_req(input int s, input rec_t r);
    in_rw[s]              = r.rw;
    in_byteen[s*DS +: DS] = r.be;
    in_addr[s*AW +: AW]   = r.addr;
    in_data[s*DW +: DW]   = r.data;
    in_tag[s*TW +: TW]    = r.tag[TOW-1:TOW-TW];
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    out_ready = 1'b1;
    for (int s = 0; s < N; s++) drive_req(s, mk_req(s));
    in_valid = '1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== '0) begin
      errors++; $display("FAIL reset_in_ready: got %b want 0000", in_ready);
    end
    checks++;
    if (out_rec() !== rec_t'(0)) begin
      errors++; $display("FAIL reset_payload: got %h want 0", out_rec());
    end
    repeat (2) @(negedge clk);
    in_valid = '0;
    reset_n  = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== '0) begin
      errors++; $display("FAIL reset_release: got out_valid=%b in_ready=%b want 0/0000", out_valid, in_ready);
    end
  endtask

  task automatic test_rr_order();
    logic [N-1:0] exp;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      in_valid  = (k < 8) ? '1 : '0;
      out_ready = 1'b1;
      #1;
      if (k < 8) begin
        exp = '0;
        exp[k % N] = 1'b1;
        checks++;
        if (in_ready !== exp) begin
          errors++; $display("FAIL rr_grant_%0d: got %b want %b", k, in_ready, exp);
        end
      end
      if (k > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_rec() !== mk_req((k - 1) % N)) begin
          errors++;
          $display("FAIL rr_out_%0d: got v=%b %h want v=1 %h", k, out_valid, out_rec(), mk_req((k - 1) % N));
        end
      end
    end
  endtask

  task automatic test_single();
    rec_t r;
    r      = mk_req(2);
    r.addr = 26'h123;
    r.tag  = {8'h5A, 2'd2};
    @(negedge clk);
    drive_req(2, r);
    in_valid = 4'b0100;
    #1;
    checks++;
    if (in_ready !== 4'b0100 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_grant: got in_ready=%b out_valid=%b want 0100/0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = '0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 10'h16A || out_addr !== 26'h123) begin
      errors++;
      $display("FAIL single_out: got v=%b tag=%h addr=%h want 1/16a/0000123", out_valid, out_tag, out_addr);
    end
    drive_req(2, mk_req(2));
  endtask

  task automatic test_wrap();
    @(negedge clk);
    in_valid = 4'b1000;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      errors++; $display("FAIL wrap_src3: got %b want 1000", in_ready);
    end
    @(negedge clk);
    in_valid = 4'b1001;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++; $display("FAIL wrap_to_src0: got %b want 0001", in_ready);
    end
    checks++;
    if (out_rec() !== mk_req(3)) begin
      errors++; $display("FAIL wrap_out3: got %h want %h", out_rec(), mk_req(3));
    end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid  = '1;
      out_ready = 1'b0;
      #1;
      checks++;
      if (in_ready !== '0 || out_valid !== 1'b1 || out_rec() !== mk_req(0)) begin
        errors++;
        $display("FAIL stall_%0d: got rdy=%b v=%b %h want 0000/1 %h", c, in_ready, out_valid, out_rec(), mk_req(0));
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++; $display("FAIL stall_ptr_kept: got %b want 0010", in_ready);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 4'b1110;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_rec() !== mk_req(1)) begin
      errors++; $display("FAIL areset_pre: got v=%b %h want 1 %h", out_valid, out_rec(), mk_req(1));
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== '0 || out_rec() !== rec_t'(0)) begin
      errors++; $display("FAIL areset_immediate: got v=%b rdy=%b %h want 0/0000/0", out_valid, in_ready, out_rec());
    end
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++; $display("FAIL areset_first_grant: got %b want 0010", in_ready);
    end
    @(negedge clk);
    in_valid = '0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_rec() !== mk_req(1)) begin
      errors++; $display("FAIL areset_out: got v=%b %h want 1 %h", out_valid, out_rec(), mk_req(1));
    end
  endtask

  task automatic test_random();
    rec_t         pend_req [N];
    logic [N-1:0] pend;
    int           waits [N];
    int           m_ptr;
    logic         m_ovld;
    logic         load;
    logic [N-1:0] exp_rdy;
    int           g;
    int           seq;
    rec_t         e;

    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    pend    = '0;
    m_ptr   = 0;
    m_ovld  = 1'b0;
    seq     = 0;
    sb.delete();
    for (int s = 0; s < N; s++) waits[s] = 0;

    for (int cyc = 0; cyc < 10060; cyc++) begin
      @(negedge clk);
      for (int s = 0; s < N; s++) begin
        if (cyc < 10000 && !pend[s] && $urandom_range(0, 2) != 0) begin
          pend_req[s].rw   = 1'($urandom);
          pend_req[s].be   = DS'($urandom);
          pend_req[s].addr = AW'(seq);
          pend_req[s].data = {$urandom, $urandom};
          pend_req[s].tag  = {TW'($urandom), 2'(s)};
          seq++;
          pend[s]  = 1'b1;
          waits[s] = 0;
          drive_req(s, pend_req[s]);
        end
      end
      in_valid  = pend;
      out_ready = (cyc >= 10000) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;

      load    = !m_ovld || out_ready;
      g       = -1;
      exp_rdy = '0;
      for (int i = 0; i < N; i++) begin
        if (g < 0 && pend[(m_ptr + i) % N]) g = (m_ptr + i) % N;
      end
      if (g >= 0 && load) exp_rdy[g] = 1'b1;

      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL rnd_in_ready c%0d: got %b want %b", cyc, in_ready, exp_rdy);
      end
      checks++;
      if (out_valid !== m_ovld) begin
        errors++; $display("FAIL rnd_out_valid c%0d: got %b want %b", cyc, out_valid, m_ovld);
      end

      if (m_ovld && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rnd_sb_empty c%0d: got output with no expected entry", cyc);
        end else begin
          e = sb.pop_front();
          if (out_rec() !== e) begin
            errors++; $display("FAIL rnd_payload c%0d: got %h want %h", cyc, out_rec(), e);
          end
        end
      end

      if (exp_rdy != '0) begin
        sb.push_back(pend_req[g]);
        checks++;
        if (waits[g] > N - 1) begin
          errors++; $display("FAIL rnd_fairness src%0d: waited %0d grants want <= %0d", g, waits[g], N - 1);
        end
        pend[g] = 1'b0;
        for (int s = 0; s < N; s++) if (pend[s]) waits[s]++;
        m_ptr  = (g + 1) % N;
        m_ovld = 1'b1;
      end else if (out_ready) begin
        m_ovld = 1'b0;
      end
    end

    checks++;
    if (sb.size() != 0 || pend != '0) begin
      errors++; $display("FAIL rnd_drain: got %0d queued, pend=%b want 0/0000", sb.size(), pend);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = '0;
    in_rw     = '0;
    in_byteen = '0;
    in_addr   = '0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    test_reset();
    test_rr_order();
    test_single();
    test_wrap();
    test_stall();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
